// File: rtl/img_stream_tx.sv
// img_stream_tx: reads an 8-bit grayscale frame from a synchronous RAM and
// emits it as a vsync/href/gray stream, one frame per accepted start.
// Optional build macro: IMG_STREAM_TX_PATTERN_EN adds pattern_sel, which
// replaces RAM data with a (row+col) mod 256 test pattern for the frame.
//
// state  | meaning
// IDLE   | waiting for start (accepted only once busy has dropped)
// VPRE   | vsync high, V_FRONT cycles before the first line
// ACTIVE | one line of IMG_H_DISP pixels, one RAM read per cycle
// HBLANK | href low for H_BLANK cycles between lines
// VPOST  | vsync high, V_BACK cycles after the last line
module img_stream_tx #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int H_BLANK    = 10,
  parameter int V_FRONT    = 10,
  parameter int V_BACK     = 1,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef IMG_STREAM_TX_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [7:0]        post_img_gray
);

  localparam int CW = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
  localparam int RW = (IMG_V_DISP > 1) ? $clog2(IMG_V_DISP) : 1;
  localparam int TW = 16;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_H_DISP - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_V_DISP - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VPRE   = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    VPOST  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic [RW-1:0]     row, row_nxt;
  logic [ADDR_W-1:0] addr_cnt, addr_nxt;

  logic vsync_r, href_r;
  logic vsync_d1, href_d1;
  logic accept, frame_end, rd_go;
  logic [7:0] gray_src;

  assign accept    = (state == IDLE) && start && !busy;
  // post_img_vsync is about to fall on this edge
  assign frame_end = post_img_vsync && !vsync_d1;

`ifdef IMG_STREAM_TX_PATTERN_EN
  logic       pat_mode;
  logic [7:0] pat_s1, pat_s2;

  assign rd_go    = (state == ACTIVE) && !pat_mode;
  assign gray_src = pat_mode ? pat_s2 : mem_rd_data;

  // Pattern path: latch the mode at start and pipeline row+col to match RAM latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_mode <= 1'b0;
      pat_s1   <= 8'd0;
      pat_s2   <= 8'd0;
    end else begin
      if (accept) pat_mode <= pattern_sel;
      if (state == ACTIVE) pat_s1 <= 8'(row) + 8'(col);
      pat_s2 <= pat_s1;
    end
  end
`else
  assign rd_go    = (state == ACTIVE);
  assign gray_src = mem_rd_data;
`endif

  // State, timer and pixel/address counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmr      <= '0;
      col      <= '0;
      row      <= '0;
      addr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      addr_cnt <= addr_nxt;
    end
  end

  // Next-state logic; timer is a down-counter loaded with length-1
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    col_nxt   = col;
    row_nxt   = row;
    addr_nxt  = addr_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = VPRE;
          tmr_nxt   = TW'(V_FRONT - 1);
          addr_nxt  = '0;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      VPRE: begin
        if (tmr == '0) begin
          state_nxt = ACTIVE;
          row_nxt   = '0;
          col_nxt   = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      ACTIVE: begin
        addr_nxt = addr_cnt + ADDR_W'(1);
        if (col == LAST_COL) begin
          col_nxt = '0;
          if (row == LAST_ROW) begin
            state_nxt = VPOST;
            tmr_nxt   = TW'(V_BACK - 1);
          end else begin
            row_nxt = row + RW'(1);
            if (H_BLANK == 0) begin
              state_nxt = ACTIVE;
            end else begin
              state_nxt = HBLANK;
              tmr_nxt   = TW'(H_BLANK - 1);
            end
          end
        end else begin
          col_nxt = col + CW'(1);
        end
      end
      HBLANK: begin
        if (tmr == '0) state_nxt = ACTIVE;
        else           tmr_nxt   = tmr - TW'(1);
      end
      VPOST: begin
        if (tmr == '0) state_nxt = IDLE;
        else           tmr_nxt   = tmr - TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered FSM outputs, the 2-stage video pipeline and busy/frame_done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_r        <= 1'b0;
      href_r         <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_rd_addr    <= '0;
      vsync_d1       <= 1'b0;
      href_d1        <= 1'b0;
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      post_img_gray  <= 8'd0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      vsync_r   <= (state != IDLE);
      href_r    <= (state == ACTIVE);
      mem_rd_en <= rd_go;
      if (rd_go) mem_rd_addr <= addr_cnt;

      vsync_d1       <= vsync_r;
      href_d1        <= href_r;
      post_img_vsync <= vsync_d1;
      post_img_href  <= href_d1;
      // RAM data is on the bus while href_d1 is high
      post_img_gray  <= href_d1 ? gray_src : 8'd0;

      frame_done <= frame_end;
      if (frame_end)   busy <= 1'b0;
      else if (accept) busy <= 1'b1;
    end
  end

endmodule

// File: doc/img_stream_tx.md
Name: img_stream_tx

Overview:
- Synthesizable frame transmitter: reads an 8-bit grayscale frame from an external synchronous RAM and emits it as a vsync/href/gray video stream.
- The stream has the same format consumed by the team's image-processing blocks, e.g. region binarization.
- Sits upstream of any per_img_* consumer and replaces the bench-only pixel driver on hardware.
- One frame is sent per start request; blanking lengths are set by parameters.

Parameters:
- IMG_H_DISP, 640, active pixels per line.
- IMG_V_DISP, 480, active lines per frame.
- H_BLANK, 10, href-low cycles between consecutive lines (vsync stays high).
- V_FRONT, 10, cycles vsync is high before the first href of the frame.
- V_BACK, 1, cycles vsync stays high after the last href of the frame.
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= IMG_H_DISP*IMG_V_DISP.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- rst_n, input, 1, reset: synchronous, active-low.
- start, input, 1, frame request; sampled only in IDLE.
- busy, output, 1, high while a frame is in flight, including the output pipeline.
- frame_done, output, 1, one-cycle pulse at end of frame.
- mem_rd_en, output, 1, RAM read strobe.
- mem_rd_addr, output, ADDR_W, RAM read address = row*IMG_H_DISP + col.
- mem_rd_data, input, 8, RAM read data; valid exactly 1 cycle after mem_rd_en.
- post_img_vsync, output, 1, frame valid.
- post_img_href, output, 1, line/pixel valid.
- post_img_gray, output, 8, pixel value.

Behaviour:
- Reset, while rst_n==0 at an edge:
  - all outputs 0: busy, frame_done, mem_rd_en, mem_rd_addr, post_img_*;
  - state = IDLE; row, col and address counters = 0; pipeline registers = 0.
  - Reset mid-frame aborts the frame immediately with no frame_done. The next start begins a fresh frame from address 0.
- FSM states: IDLE, VPRE, ACTIVE, HBLANK, VPOST.
- IDLE -> VPRE when start==1 at an edge.
- VPRE lasts V_FRONT cycles, then goes to ACTIVE with row=0, col=0.
- ACTIVE lasts IMG_H_DISP cycles:
  - each cycle: internal href=1, mem_rd_en=1, mem_rd_addr=address counter; then the counter increments.
  - at col==IMG_H_DISP-1: if row==IMG_V_DISP-1, go to VPOST; else go to HBLANK and increment row.
- HBLANK lasts H_BLANK cycles, then goes to ACTIVE with col=0. If H_BLANK==0, ACTIVE goes directly to ACTIVE.
- VPOST lasts V_BACK cycles, then goes to IDLE.
- Internal vsync is 1 in VPRE, ACTIVE, HBLANK and VPOST. mem_rd_en and mem_rd_addr are registered FSM outputs.
- Output pipeline: post_img_vsync and post_img_href are the internal vsync/href delayed 2 clk. post_img_gray is mem_rd_data registered on the cycle after data return, so gray aligns with href.
  - post_img_gray = 0 whenever post_img_href==0.
  - mem_rd_addr holds its last value when mem_rd_en==0.
- Frame timing:
  - vsync high time = V_FRONT + IMG_V_DISP*IMG_H_DISP + (IMG_V_DISP-1)*H_BLANK + V_BACK cycles;
  - href is contiguous for IMG_H_DISP cycles per line.
- busy rises on the edge start is accepted and falls on the edge post_img_vsync falls.
- frame_done pulses in the same cycle post_img_vsync first reads 0.
- start while busy==1 is ignored and not queued. start on the same edge busy falls is also ignored; it is accepted on the following edge.
- Address arithmetic: ADDR_W-bit counter cleared on entry to VPRE. Last address = IMG_H_DISP*IMG_V_DISP-1; no wrap within a frame.

Optional Feature:
- Macro IMG_STREAM_TX_PATTERN_EN.
- When defined:
  - adds input pattern_sel (1 bit), sampled and latched when start is accepted;
  - if the latched value is 1: mem_rd_en stays 0 for the frame and post_img_gray = (row+col) mod 256 of the pixel. Timing and latency are identical to the RAM path.
  - if the latched value is 0: behaviour as without the macro.
- When undefined: no pattern_sel port; gray always comes from RAM.

Test Plan:
- Small params (IMG_H_DISP=4, IMG_V_DISP=3, H_BLANK=2, V_FRONT=3, V_BACK=1), RAM[i]=i, one start pulse:
  - post_img_vsync high exactly 20 cycles;
  - 3 href bursts of 4 cycles separated by 2 low cycles;
  - gray sequence 00..0B;
  - frame_done pulses once as vsync falls.
- Same config, RAM returns data 1 cycle after mem_rd_en: first href cycle carries RAM[0]; mem_rd_addr 0..11 each issued exactly once, in order; gray=0 in every blank cycle.
- start pulses every cycle during the frame: exactly one frame emitted. A start 1 cycle after frame_done begins a second identical frame.
- rst_n=0 for 1 cycle during line 2: all outputs 0 on the next cycle, no frame_done. A following start yields a full frame starting at RAM[0].
- Defaults 640x480: 480 lines of 640 href cycles; vsync high 10+307200+4790+1=312001 cycles; last mem_rd_addr=307199.
- With IMG_STREAM_TX_PATTERN_EN and pattern_sel=1, small config: mem_rd_en never asserted; row 2 gray = 02,03,04,05.
